// File: rtl/keypad_word_assembler.sv
// Assembles debounced keypad codes into 4-digit words {chg_flag, value} with
// backspace, clear, change-flag toggle and an inactivity auto-clear.
module keypad_word_assembler #(
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int CNT_W          = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [16:0] data_out,
    output logic        data_load,
    output logic [2:0]  digit_count,
    output logic        chg_flag,
    output logic        entry_error,
    output logic        timeout
);

    localparam logic [3:0] KEY_CHG = 4'hA;
    localparam logic [3:0] KEY_BSP = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_ENT = 4'hE;
    localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;

    // Expiry compares against the counter value before the final idle increment.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    // The entry state is the digit count itself; this is its named view.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } view_t;

    logic [15:0]      acc_q,   acc_d;
    logic [2:0]       count_q, count_d;
    logic             chg_q,   chg_d;
    logic [16:0]      data_q,  data_d;
    logic             load_q,  load_d;
    logic             err_q,   err_d;
    logic             tmo_q,   tmo_d;
    logic [CNT_W-1:0] tcnt_q,  tcnt_d;
    view_t            view;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q   <= '0;
            count_q <= '0;
            chg_q   <= 1'b0;
            data_q  <= '0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            chg_q   <= chg_d;
            data_q  <= data_d;
            load_q  <= load_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        if (count_q == 3'd0) begin
            view = EMPTY;
        end else if (count_q == 3'd4) begin
            view = FULL;
        end else begin
            view = PARTIAL;
        end
    end

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        chg_d   = chg_q;
        data_d  = data_q;
        load_d  = 1'b0;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        tcnt_d  = tcnt_q;

        if (key_valid) begin
            // A key always restarts the idle window, even one that is rejected.
            tcnt_d = '0;
            case (key_code)
                KEY_CHG: chg_d = ~chg_q;
                KEY_BSP: begin
                    if (view == EMPTY) begin
                        err_d = 1'b1;
                    end else begin
                        acc_d   = {4'h0, acc_q[15:4]};
                        count_d = count_q - 3'd1;
                    end
                end
                KEY_CLR: begin
                    acc_d   = '0;
                    count_d = '0;
                    chg_d   = 1'b0;
                end
                KEY_ENT: begin
                    if (view == FULL) begin
                        data_d  = {chg_q, acc_q};
                        load_d  = 1'b1;
                        acc_d   = '0;
                        count_d = '0;
                        chg_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    if (key_code <= KEY_MAX_DIGIT && view != FULL) begin
                        acc_d   = {acc_q[11:0], key_code};
                        count_d = count_q + 3'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end else if (view != EMPTY || chg_q) begin
            if (tcnt_q == TMO_LAST) begin
                acc_d   = '0;
                count_d = '0;
                chg_d   = 1'b0;
                tcnt_d  = '0;
                tmo_d   = 1'b1;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end else begin
            tcnt_d = '0;
        end
    end

    assign data_out    = data_q;
    assign data_load   = load_q;
    assign digit_count = count_q;
    assign chg_flag    = chg_q;
    assign entry_error = err_q;
    assign timeout     = tmo_q;

endmodule

// File: tb/tb_keypad_word_assembler.sv
// Directed bench for keypad_word_assembler: a vector table of one-cycle steps
// plus hand-written timeout sequences, using a 10-cycle timeout.
module tb_keypad_word_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [16:0] data_out;
    logic        data_load;
    logic [2:0]  digit_count;
    logic        chg_flag;
    logic        entry_error;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    keypad_word_assembler #(
        .TIMEOUT_CYCLES(10),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .key_valid(key_valid),
        .key_code(key_code),
        .data_out(data_out),
        .data_load(data_load),
        .digit_count(digit_count),
        .chg_flag(chg_flag),
        .entry_error(entry_error),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        kv;
        logic [3:0]  code;
        logic [16:0] dout;
        logic        load;
        logic [2:0]  cnt;
        logic        chg;
        logic        err;
        logic        tmo;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic r, input logic kv, input logic [3:0] code,
                                    input logic [16:0] dout, input logic load, input logic [2:0] cnt,
                                    input logic chg, input logic err, input logic tmo);
        vec_t v;
        v.rst_n = r; v.kv = kv; v.code = code; v.dout = dout; v.load = load;
        v.cnt = cnt; v.chg = chg; v.err = err; v.tmo = tmo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock step: drive inputs, let the edge pass, compare all outputs.
    task automatic step(input string tag, input logic r, input logic kv, input logic [3:0] code,
                        input logic [16:0] dout, input logic load, input logic [2:0] cnt,
                        input logic chg, input logic err, input logic tmo);
        rst = r; key_valid = kv; key_code = code;
        @(posedge clk);
        #1;
        check({tag, ".data_out"},    data_out,           dout);
        check({tag, ".data_load"},   17'(data_load),     17'(load));
        check({tag, ".digit_count"}, 17'(digit_count),   17'(cnt));
        check({tag, ".chg_flag"},    17'(chg_flag),      17'(chg));
        check({tag, ".entry_error"}, 17'(entry_error),   17'(err));
        check({tag, ".timeout"},     17'(timeout),       17'(tmo));
    endtask

    initial begin
        rst = 1'b0; key_valid = 1'b0; key_code = 4'h0;

        // rst kv code  dout       load cnt chg err tmo
        add_vec(0, 0, 4'h0, 17'h00000, 0, 0, 0, 0, 0);
        add_vec(0, 1, 4'h5, 17'h00000, 0, 0, 0, 0, 0); // reset beats a key
        add_vec(1, 1, 4'h1, 17'h00000, 0, 1, 0, 0, 0);
        add_vec(1, 1, 4'h2, 17'h00000, 0, 2, 0, 0, 0);
        add_vec(1, 1, 4'h3, 17'h00000, 0, 3, 0, 0, 0);
        add_vec(1, 1, 4'h4, 17'h00000, 0, 4, 0, 0, 0);
        add_vec(1, 1, 4'hE, 17'h01234, 1, 0, 0, 0, 0);
        add_vec(1, 0, 4'h0, 17'h01234, 0, 0, 0, 0, 0);
        add_vec(1, 1, 4'hA, 17'h01234, 0, 0, 1, 0, 0);
        add_vec(1, 1, 4'h0, 17'h01234, 0, 1, 1, 0, 0);
        add_vec(1, 1, 4'h0, 17'h01234, 0, 2, 1, 0, 0);
        add_vec(1, 1, 4'h0, 17'h01234, 0, 3, 1, 0, 0);
        add_vec(1, 1, 4'h7, 17'h01234, 0, 4, 1, 0, 0);
        add_vec(1, 1, 4'hE, 17'h10007, 1, 0, 0, 0, 0);
        add_vec(1, 1, 4'h5, 17'h10007, 0, 1, 0, 0, 0);
        add_vec(1, 1, 4'h5, 17'h10007, 0, 2, 0, 0, 0);
        add_vec(1, 1, 4'h5, 17'h10007, 0, 3, 0, 0, 0);
        add_vec(1, 1, 4'h5, 17'h10007, 0, 4, 0, 0, 0);
        add_vec(1, 1, 4'h5, 17'h10007, 0, 4, 0, 1, 0); // fifth digit rejected
        add_vec(1, 1, 4'hE, 17'h05555, 1, 0, 0, 0, 0);
        add_vec(1, 1, 4'h9, 17'h05555, 0, 1, 0, 0, 0);
        add_vec(1, 1, 4'h8, 17'h05555, 0, 2, 0, 0, 0);
        add_vec(1, 1, 4'hB, 17'h05555, 0, 1, 0, 0, 0);
        add_vec(1, 1, 4'h7, 17'h05555, 0, 2, 0, 0, 0);
        add_vec(1, 1, 4'h6, 17'h05555, 0, 3, 0, 0, 0);
        add_vec(1, 1, 4'h5, 17'h05555, 0, 4, 0, 0, 0);
        add_vec(1, 1, 4'hE, 17'h09765, 1, 0, 0, 0, 0);
        add_vec(1, 1, 4'hB, 17'h09765, 0, 0, 0, 1, 0); // backspace on empty
        add_vec(1, 1, 4'hA, 17'h09765, 0, 0, 1, 0, 0);
        add_vec(1, 1, 4'h1, 17'h09765, 0, 1, 1, 0, 0);
        add_vec(1, 1, 4'h2, 17'h09765, 0, 2, 1, 0, 0);
        add_vec(1, 1, 4'hE, 17'h09765, 0, 2, 1, 1, 0); // short enter
        add_vec(1, 1, 4'hC, 17'h09765, 0, 0, 0, 0, 0);
        add_vec(1, 1, 4'hD, 17'h09765, 0, 0, 0, 1, 0);
        add_vec(1, 1, 4'hF, 17'h09765, 0, 0, 0, 1, 0);
        add_vec(1, 1, 4'hE, 17'h09765, 0, 0, 0, 1, 0);
        add_vec(1, 1, 4'h4, 17'h09765, 0, 1, 0, 0, 0);
        add_vec(1, 1, 4'h3, 17'h09765, 0, 2, 0, 0, 0);
        add_vec(1, 1, 4'h2, 17'h09765, 0, 3, 0, 0, 0);
        add_vec(1, 1, 4'h1, 17'h09765, 0, 4, 0, 0, 0);
        add_vec(1, 1, 4'hE, 17'h04321, 1, 0, 0, 0, 0);
        add_vec(1, 1, 4'h6, 17'h04321, 0, 1, 0, 0, 0); // key during data_load
        add_vec(1, 1, 4'hC, 17'h04321, 0, 0, 0, 0, 0);
        add_vec(1, 0, 4'h0, 17'h04321, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].kv, vecs[i].code,
                 vecs[i].dout, vecs[i].load, vecs[i].cnt, vecs[i].chg, vecs[i].err, vecs[i].tmo);
        end

        // Timeout: one digit, eight quiet idles, expiry on the ninth.
        step("tmo_key", 1, 1, 4'h3, 17'h04321, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step($sformatf("tmo_idle%0d", i), 1, 0, 4'h0, 17'h04321, 0, 1, 0, 0, 0);
        step("tmo_expire", 1, 0, 4'h0, 17'h04321, 0, 0, 0, 0, 1);
        step("tmo_after",  1, 0, 4'h0, 17'h04321, 0, 0, 0, 0, 0);

        // Key on the expiry cycle wins.
        step("race_key", 1, 1, 4'h3, 17'h04321, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step($sformatf("race_idle%0d", i), 1, 0, 4'h0, 17'h04321, 0, 1, 0, 0, 0);
        step("race_hit",   1, 1, 4'h4, 17'h04321, 0, 2, 0, 0, 0);
        step("race_after", 1, 0, 4'h0, 17'h04321, 0, 2, 0, 0, 0);
        step("race_clr",   1, 1, 4'hC, 17'h04321, 0, 0, 0, 0, 0);

        // The change flag alone keeps the idle counter running.
        step("chg_key", 1, 1, 4'hA, 17'h04321, 0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step($sformatf("chg_idle%0d", i), 1, 0, 4'h0, 17'h04321, 0, 0, 1, 0, 0);
        step("chg_expire", 1, 0, 4'h0, 17'h04321, 0, 0, 0, 0, 1);

        // Empty and flag clear: counter stays idle, no spurious timeout.
        for (int i = 0; i < 12; i++) step($sformatf("quiet%0d", i), 1, 0, 4'h0, 17'h04321, 0, 0, 0, 0, 0);

        // Mid-entry reset, then a fresh word carries chg_flag=0.
        step("mid_k1", 1, 1, 4'h1, 17'h04321, 0, 1, 0, 0, 0);
        step("mid_k2", 1, 1, 4'h2, 17'h04321, 0, 2, 0, 0, 0);
        step("mid_kA", 1, 1, 4'hA, 17'h04321, 0, 2, 1, 0, 0);
        step("mid_rst", 0, 0, 4'h0, 17'h00000, 0, 0, 0, 0, 0);
        step("mid_d8", 1, 1, 4'h8, 17'h00000, 0, 1, 0, 0, 0);
        step("mid_d0", 1, 1, 4'h0, 17'h00000, 0, 2, 0, 0, 0);
        step("mid_d2", 1, 1, 4'h2, 17'h00000, 0, 3, 0, 0, 0);
        step("mid_d9", 1, 1, 4'h9, 17'h00000, 0, 4, 0, 0, 0);
        step("mid_ent", 1, 1, 4'hE, 17'h08029, 1, 0, 0, 0, 0);
        step("mid_end", 1, 0, 4'h0, 17'h08029, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
